// File: rtl/mux_pipe_pkg.sv
// Shared elaboration helpers for the pipelined N-input selector: stage geometry
// and the offsets used to pack every stage's candidates into one flat bus.
package mux_pipe_pkg;

    function automatic int stage_count(input int address, input int stage_bits);
        return (address + stage_bits - 32'sd1) / stage_bits;
    endfunction

    function automatic int stage_sel_lo(input int k, input int stage_bits);
        return k * stage_bits;
    endfunction

    function automatic int stage_sel_bits(input int k, input int address, input int stage_bits);
        int rem;
        rem = address - stage_sel_lo(k, stage_bits);
        return (rem < stage_bits) ? rem : stage_bits;
    endfunction

    // Candidates entering stage j; j == stage_count yields the single output word.
    function automatic int cand_cnt(input int j, input int address, input int stage_bits);
        int lo;
        lo = stage_sel_lo(j, stage_bits);
        lo = (lo > address) ? address : lo;
        return 32'sd1 << (address - lo);
    endfunction

    function automatic int data_off(input int j, input int address, input int stage_bits);
        int acc;
        acc = 32'sd0;
        for (int i = 0; i < j; i++) acc += cand_cnt(i, address, stage_bits);
        return acc;
    endfunction

    function automatic int sel_off(input int k, input int address, input int stage_bits);
        int acc;
        acc = 32'sd0;
        for (int i = 0; i < k; i++) acc += address - stage_sel_lo(i, stage_bits);
        return acc;
    endfunction

    function automatic bit params_legal(input int address, input int stage_bits);
        return (address >= 32'sd1) && (stage_bits >= 32'sd1) && (stage_bits <= address);
    endfunction

endpackage

// File: rtl/mux_pipe_n_if.sv
// Upstream/downstream handshake and data bus of the pipelined selector.
interface mux_pipe_n_if #(
    parameter int n       = 4,
    parameter int address = 8
);
    logic         flush_i;
    logic         valid_i;
    logic         ready_o;
    logic [n-1:0] data_i [2**address];
    logic [address-1:0] sel;
    logic         valid_o;
    logic         ready_i;
    logic [n-1:0] data_o;

    modport slave (
        input  flush_i, valid_i, data_i, sel, ready_i,
        output ready_o, valid_o, data_o
    );

    modport master (
        output flush_i, valid_i, data_i, sel, ready_i,
        input  ready_o, valid_o, data_o
    );
endinterface

// File: rtl/mux_stage_n.sv
// One registered radix stage: picks one word per group of 2**sel_bits inputs
// and carries the still-unused upper select bits alongside the result.
module mux_stage_n #(
    parameter int n        = 4,
    parameter int in_cnt   = 16,
    parameter int sel_bits = 4,
    parameter int sel_w    = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic [in_cnt*n-1:0]                 data_i,
    input  logic [sel_w-1:0]                    sel_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [(in_cnt >> sel_bits)*n-1:0]   data_o,
    output logic [((sel_w > sel_bits) ? sel_w - sel_bits : 1)-1:0] sel_o
);
    localparam int R       = 1 << sel_bits;
    localparam int OUT_CNT = in_cnt / R;
    localparam int IW      = $clog2(in_cnt);
    localparam int CARRY_W = sel_w - sel_bits;

    logic [n-1:0]         in_arr_s [in_cnt];
    logic [OUT_CNT*n-1:0] cand_s;
    logic [OUT_CNT*n-1:0] data_d, data_q;
    logic                 valid_d, valid_q;
    logic                 load_s, take_s;

    for (genvar i = 0; i < in_cnt; i++) begin : g_unpack
        assign in_arr_s[i] = data_i[i*n +: n];
    end

    for (genvar g = 0; g < OUT_CNT; g++) begin : g_group
        logic [IW-1:0] idx_s;
        assign idx_s             = IW'(g * R) + IW'(sel_i[sel_bits-1:0]);
        assign cand_s[g*n +: n]  = in_arr_s[idx_s];
    end

    // An empty stage always loads, so bubbles collapse even under backpressure.
    assign load_s  = !valid_q || ready_i;
    assign take_s  = load_s && valid_i && !flush_i;
    assign ready_o = load_s;
    assign data_d  = take_s ? cand_s : data_q;

    // Next valid: flush wins over any load.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_s) begin
            valid_d = valid_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage valid and candidate registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

    if (CARRY_W > 0) begin : g_carry
        logic [CARRY_W-1:0] carry_d, carry_q;
        assign carry_d = take_s ? sel_i[sel_w-1:sel_bits] : carry_q;

        // Upper select bits travel with the candidates.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                carry_q <= '0;
            end else begin
                carry_q <= carry_d;
            end
        end
        assign sel_o = carry_q;
    end else begin : g_no_carry
        assign sel_o = 1'b0;
    end

endmodule

// File: rtl/mux_pipe_n.sv
// Pipelined 2**address-to-1 selector of n-bit words with valid/ready flow control;
// the tree is cut into registered radix-2**stage_bits stages.
module mux_pipe_n
    import mux_pipe_pkg::*;
#(
    parameter int n          = 4,
    parameter int address    = 8,
    parameter int stage_bits = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    mux_pipe_n_if.slave  bus
);
    localparam int stages   = stage_count(address, stage_bits);
    localparam int DATA_TOT = data_off(stages + 1, address, stage_bits);
    localparam int SEL_TOT  = sel_off(stages, address, stage_bits);

    if (!params_legal(address, stage_bits)) begin : g_param_check
        $error("mux_pipe_n: stage_bits must lie in 1..address");
    end

    // Flat buses: segment j holds the candidates (or select bits) entering stage j.
    logic [DATA_TOT*n-1:0] data_flat_s;
    logic [SEL_TOT-1:0]    sel_flat_s;
    logic [stages:0]       valid_s;
    logic [stages:0]       ready_s;

    for (genvar i = 0; i < (1 << address); i++) begin : g_in
        assign data_flat_s[i*n +: n] = bus.data_i[i];
    end

    assign sel_flat_s[address-1:0] = bus.sel;
    assign valid_s[0]              = bus.valid_i;
    assign bus.ready_o             = ready_s[0];
    assign ready_s[stages]         = bus.ready_i;
    assign bus.valid_o             = valid_s[stages];
    assign bus.data_o              = data_flat_s[data_off(stages, address, stage_bits)*n +: n];

    for (genvar k = 0; k < stages; k++) begin : g_stage
        localparam int IN_CNT  = cand_cnt(k, address, stage_bits);
        localparam int OUT_CNT = cand_cnt(k + 1, address, stage_bits);
        localparam int SEL_W   = address - stage_sel_lo(k, stage_bits);
        localparam int BITS    = stage_sel_bits(k, address, stage_bits);
        localparam int CW      = (SEL_W > BITS) ? SEL_W - BITS : 1;

        logic [CW-1:0] carry_s;

        mux_stage_n #(
            .n        (n),
            .in_cnt   (IN_CNT),
            .sel_bits (BITS),
            .sel_w    (SEL_W)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (bus.flush_i),
            .valid_i (valid_s[k]),
            .ready_o (ready_s[k]),
            .data_i  (data_flat_s[data_off(k, address, stage_bits)*n +: IN_CNT*n]),
            .sel_i   (sel_flat_s[sel_off(k, address, stage_bits) +: SEL_W]),
            .valid_o (valid_s[k+1]),
            .ready_i (ready_s[k+1]),
            .data_o  (data_flat_s[data_off(k + 1, address, stage_bits)*n +: OUT_CNT*n]),
            .sel_o   (carry_s)
        );

        if (k < stages - 1) begin : g_fwd
            assign sel_flat_s[sel_off(k + 1, address, stage_bits) +: CW] = carry_s;
        end else begin : g_last
            logic [CW-1:0] carry_unused_s;
            assign carry_unused_s = carry_s;
        end
    end

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed bench for mux_pipe_n: latency, streaming, backpressure, flush and
// asynchronous reset on a radix-16 build, plus a radix-8 build with a narrow last stage.
module tb_mux_pipe_n;

    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    mux_pipe_n_if #(.n(8), .address(8)) if_a ();
    mux_pipe_n_if #(.n(8), .address(8)) if_b ();

    mux_pipe_n #(.n(8), .address(8), .stage_bits(4)) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if_a.slave)
    );

    mux_pipe_n #(.n(8), .address(8), .stage_bits(3)) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] t2_sel   [4]  = '{8'h00, 8'hFF, 8'h80, 8'h01};
    int         t2_exp_v [6]  = '{0, 1, 1, 1, 1, 0};
    logic [7:0] t2_exp_d [6]  = '{8'h00, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h00};
    logic [7:0] bp_items [6]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int         bp_rdy   [13] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    int         bp_exp_r [13] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    int         bp_exp_v [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] bp_exp_d [13] = '{8'h00, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22,
                                  8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};

    initial begin
        int idx;
        rst_n = 1'b1;
        for (int k = 0; k < 256; k++) begin
            if_a.data_i[k] = 8'(k);
            if_b.data_i[k] = 8'(k);
        end
        if_a.flush_i = 1'b0; if_a.valid_i = 1'b0; if_a.sel = 8'h00; if_a.ready_i = 1'b1;
        if_b.flush_i = 1'b0; if_b.valid_i = 1'b0; if_b.sel = 8'h00; if_b.ready_i = 1'b1;

        // reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid_a", if_a.valid_o, 32'd0);
        check("rst_data_a",  if_a.data_o,  32'd0);
        check("rst_valid_b", if_b.valid_o, 32'd0);
        check("rst_data_b",  if_b.data_o,  32'd0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_ready_a", if_a.ready_o, 32'd1);
        check("post_rst_ready_b", if_b.ready_o, 32'd1);

        // single transfer, two-cycle latency
        if_a.sel = 8'hA5; if_a.valid_i = 1'b1;
        tick();
        if_a.valid_i = 1'b0;
        check("t1_valid_c1", if_a.valid_o, 32'd0);
        tick();
        check("t1_valid_c2", if_a.valid_o, 32'd1);
        check("t1_data_c2",  if_a.data_o,  32'hA5);
        tick();
        check("t1_valid_c3", if_a.valid_o, 32'd0);

        // back-to-back stream at full rate
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                if_a.sel = t2_sel[c]; if_a.valid_i = 1'b1;
            end else begin
                if_a.valid_i = 1'b0;
            end
            tick();
            check($sformatf("t2_valid[%0d]", c), if_a.valid_o, t2_exp_v[c]);
            if (t2_exp_v[c] != 0) check($sformatf("t2_data[%0d]", c), if_a.data_o, t2_exp_d[c]);
        end

        // backpressure: ready_i low before edges 3..7
        idx = 0;
        for (int c = 0; c < 13; c++) begin
            if_a.ready_i = bp_rdy[c][0];
            if (idx < 6) begin
                if_a.valid_i = 1'b1; if_a.sel = bp_items[idx];
            end else begin
                if_a.valid_i = 1'b0;
            end
            #1;
            check($sformatf("bp_ready[%0d]", c), if_a.ready_o, bp_exp_r[c]);
            if (bp_exp_r[c] != 0 && idx < 6) idx++;
            tick();
            check($sformatf("bp_valid[%0d]", c), if_a.valid_o, bp_exp_v[c]);
            if (bp_exp_v[c] != 0) check($sformatf("bp_data[%0d]", c), if_a.data_o, bp_exp_d[c]);
        end
        if_a.ready_i = 1'b1;

        // three-stage build, last stage consumes two bits
        if_b.sel = 8'hC7; if_b.valid_i = 1'b1;
        tick();
        if_b.sel = 8'h3D;
        check("b_valid_c1", if_b.valid_o, 32'd0);
        tick();
        if_b.valid_i = 1'b0;
        check("b_valid_c2", if_b.valid_o, 32'd0);
        tick();
        check("b_valid_c3", if_b.valid_o, 32'd1);
        check("b_data_c3",  if_b.data_o,  32'hC7);
        tick();
        check("b_valid_c4", if_b.valid_o, 32'd1);
        check("b_data_c4",  if_b.data_o,  32'h3D);
        tick();
        check("b_valid_c5", if_b.valid_o, 32'd0);

        // flush with two items in flight
        if_a.sel = 8'h12; if_a.valid_i = 1'b1;
        tick();
        check("fl_valid_c1", if_a.valid_o, 32'd0);
        if_a.sel = 8'h34; if_a.flush_i = 1'b1;
        tick();
        if_a.flush_i = 1'b0;
        check("fl_valid_c2", if_a.valid_o, 32'd0);
        check("fl_ready_c2", if_a.ready_o, 32'd1);
        if_a.sel = 8'h33;
        tick();
        if_a.valid_i = 1'b0;
        check("fl_valid_c3", if_a.valid_o, 32'd0);
        tick();
        check("fl_valid_c4", if_a.valid_o, 32'd1);
        check("fl_data_c4",  if_a.data_o,  32'h33);
        tick();
        check("fl_valid_c5", if_a.valid_o, 32'd0);

        // asynchronous reset mid-stream
        if_a.sel = 8'h44; if_a.valid_i = 1'b1;
        tick();
        if_a.sel = 8'h55;
        tick();
        if_a.valid_i = 1'b0;
        check("ar_valid_pre", if_a.valid_o, 32'd1);
        check("ar_data_pre",  if_a.data_o,  32'h44);
        rst_n = 1'b0;
        #1;
        check("ar_valid_async", if_a.valid_o, 32'd0);
        check("ar_data_async",  if_a.data_o,  32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("ar_ready_rel", if_a.ready_o, 32'd1);
        tick();
        check("ar_valid_rel1", if_a.valid_o, 32'd0);
        tick();
        check("ar_valid_rel2", if_a.valid_o, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
